// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode constants, fetch FSM encoding and queue entry type shared by the RV32I core
package rv32i_pkg;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 2;
   typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT} fetch_state_e;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {instr, pc} FIFO with push, pop and synchronous flush (flush beats push)
// Ports: clk, rst (async active-low), flush, push/push_data, pop (caller guarantees non-empty),
//        head (oldest entry), count, full, empty.
module fetch_queue
   import rv32i_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   fetch_entry_t mem_q [FIFO_DEPTH];
   fetch_entry_t mem_d [FIFO_DEPTH];
   logic         rd_q, rd_d, wr_q, wr_d;
   logic [1:0]   count_q, count_d;

   assign head  = mem_q[rd_q];
   assign count = count_q;
   assign full  = count_q == 2'(FIFO_DEPTH);
   assign empty = count_q == 2'd0;

   always_comb begin
      mem_d   = mem_q;
      rd_d    = flush ? wr_q : rd_q ^ pop;
      wr_d    = flush ? wr_q : wr_q ^ push;
      count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
      if (push && !flush) mem_d[wr_q] = push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q   <= '{default: '0};
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage; PC, one-outstanding imem req/gnt/rvalid, 2-entry decode queue
// Ports: clk, rst (async active-low); imem_req/addr/gnt/rvalid/rdata to instruction memory;
//        redirect_valid/pc from execute; id_valid/ready/instr/pc/pc_plus4/op to decode.
module instr_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [6:0]  id_op
);
   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, inflight_pc_q, inflight_pc_d;
   logic         discard_q, discard_d, push, pop, grant, q_full, q_empty;
   logic [1:0]   q_count;
   fetch_entry_t head;

   // Queue space is reserved at issue time, so a grant never leads to overflow.
   assign imem_req    = (state_q == ST_REQ) && !q_full;
   assign imem_addr   = pc_q;
   assign grant       = imem_req && imem_gnt;
   assign pop         = id_ready && !q_empty;
   assign id_valid    = q_count != 2'd0;
   assign id_instr    = head.instr;
   assign id_pc       = head.pc;
   assign id_pc_plus4 = head.pc + 32'd4;
   assign id_op       = head.instr[6:0];

   always_comb begin
      state_d       = state_q == ST_BOOT ? ST_REQ : state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      discard_d     = discard_q;
      push          = 1'b0;
      if (grant) begin
         inflight_pc_d = pc_q;
         pc_d          = pc_q + 32'd4;
         state_d       = ST_WAIT;
      end
      if (state_q == ST_WAIT && imem_rvalid) begin
         push      = !discard_q;
         discard_d = 1'b0;
         state_d   = ST_REQ;
      end
      // A request still in flight when the redirect lands belongs to the old path.
      if (redirect_valid) begin
         pc_d      = redirect_pc & ~32'd3;
         push      = 1'b0;
         discard_d = grant || (state_q == ST_WAIT && !imem_rvalid);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         inflight_pc_q <= 32'd0;
         discard_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         discard_q     <= discard_d;
      end
   end

   fetch_queue u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({imem_rdata, inflight_pc_q}),
      .pop       (pop),
      .head      (head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios checked against a transaction-level fetch model
module tb_instr_fetch_unit;
   import rv32i_pkg::*;

   logic clk = 1'b0, rst, sel;
   logic imem_gnt, imem_rvalid, redirect_valid, id_ready;
   logic [31:0] imem_rdata, redirect_pc;
   logic        o_req [2];
   logic [31:0] o_addr [2];
   logic        o_valid [2];
   logic [31:0] o_instr [2];
   logic [31:0] o_pc [2];
   logic [31:0] o_pc4 [2];
   logic [6:0]  o_op [2];
   logic imem_req, id_valid;
   logic [31:0] imem_addr, id_instr, id_pc, id_pc_plus4;
   logic [6:0] id_op;
   logic rst0, rst1;

   int checks = 0, failures = 0;
   logic rdr;
   logic [31:0] rdr_pc, slow_addr, resp_addr;
   int gnt_delay, r_lat, resp_cnt, gnt_wait;

   logic [31:0] mq[$];
   logic [31:0] grant_log[$], pop_log[$], req_log[$];
   bit boot, outst, live;
   logic [31:0] exp_pc, fl_pc;

   always #5 clk = ~clk;

   assign rst0 = rst & ~sel;
   assign rst1 = rst & sel;
   assign imem_req    = o_req[sel];
   assign imem_addr   = o_addr[sel];
   assign id_valid    = o_valid[sel];
   assign id_instr    = o_instr[sel];
   assign id_pc       = o_pc[sel];
   assign id_pc_plus4 = o_pc4[sel];
   assign id_op       = o_op[sel];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst0), .imem_req(o_req[0]), .imem_addr(o_addr[0]), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .id_valid(o_valid[0]), .id_ready(id_ready), .id_instr(o_instr[0]),
      .id_pc(o_pc[0]), .id_pc_plus4(o_pc4[0]), .id_op(o_op[0]));

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rst(rst1), .imem_req(o_req[1]), .imem_addr(o_addr[1]), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .id_valid(o_valid[1]), .id_ready(id_ready), .id_instr(o_instr[1]),
      .id_pc(o_pc[1]), .id_pc_plus4(o_pc4[1]), .id_op(o_op[1]));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [6:0] op;
      if (a == 32'h0) return 32'h0050_0093;
      case (a[3:2])
         2'd0: op = OP_ITYPE;
         2'd1: op = OP_LOAD;
         2'd2: op = OP_RTYPE;
         default: op = OP_BRANCH;
      endcase
      return {a[26:2], op};
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return i < q.size() ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: grants after gnt_delay stalled cycles (only for slow_addr), answers r_lat cycles later.
   task automatic tick();
      logic g, rq;
      logic [31:0] ga;
      rq = imem_req;
      ga = imem_addr;
      g  = imem_req && (gnt_wait >= ((imem_addr == slow_addr) ? gnt_delay : 0));
      imem_gnt = g;
      imem_rvalid = (resp_cnt == 0);
      imem_rdata = imem_rvalid ? mem_word(resp_addr) : $urandom;
      redirect_valid = rdr;
      redirect_pc = rdr_pc;
      @(posedge clk);
      #2;
      rdr = 1'b0;
      if (imem_rvalid) resp_cnt = -1;
      else if (resp_cnt > 0) resp_cnt--;
      if (g) begin
         resp_cnt = r_lat - 1;
         resp_addr = ga;
         gnt_wait = 0;
      end else if (rq) gnt_wait++;
      else gnt_wait = 0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset(input logic s);
      rst = 1'b0;
      sel = s;
      repeat (3) tick();
      grant_log.delete();
      pop_log.delete();
      req_log.delete();
      gnt_delay = 0;
      slow_addr = 32'h1;
      r_lat = 1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !id_valid; i++) tick();
      chk("wait_valid", 32'(id_valid), 32'd1);
   endtask

   task automatic wait_grants(input int n);
      for (int i = 0; i < 20 && grant_log.size() < n; i++) tick();
      chk("wait_grants", grant_log.size(), n);
   endtask

   // Transaction-level model: expected next fetch address, in-flight request liveness,
   // and the ordered list of PCs that decode should see.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_valid", 32'(id_valid), 32'd0);
         chk("rst_instr", id_instr, 32'd0);
         chk("rst_pc", id_pc, 32'd0);
         chk("rst_op", 32'(id_op), 32'd0);
         mq.delete();
         boot = 1;
         outst = 0;
         live = 0;
         exp_pc = sel ? 32'hFFFF_FFFC : 32'h0;
      end else begin
         chk("req", 32'(imem_req), 32'(!boot && !outst && mq.size() < 2));
         if (imem_req) begin
            chk("addr", imem_addr, exp_pc);
            req_log.push_back(imem_addr);
         end
         chk("valid", 32'(id_valid), 32'(mq.size() != 0));
         if (id_valid && mq.size() != 0) begin
            chk("id_pc", id_pc, mq[0]);
            chk("id_instr", id_instr, mem_word(mq[0]));
            chk("id_op", 32'(id_op), 32'(mem_word(mq[0]) & 32'h7F));
            chk("id_pc_plus4", id_pc_plus4, mq[0] + 32'd4);
         end
         if (boot) begin
            boot = 0;
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
         end else if (redirect_valid) begin
            if (imem_req && imem_gnt) begin
               grant_log.push_back(imem_addr);
               outst = 1;
               live = 0;
            end else if (outst && imem_rvalid) outst = 0;
            else live = 0;
            mq.delete();
            exp_pc = redirect_pc & ~32'd3;
         end else begin
            if (id_valid && id_ready && mq.size() != 0) begin
               pop_log.push_back(mq[0]);
               void'(mq.pop_front());
            end
            if (outst && imem_rvalid) begin
               if (live) mq.push_back(fl_pc);
               outst = 0;
            end
            if (imem_req && imem_gnt) begin
               grant_log.push_back(imem_addr);
               outst = 1;
               live = 1;
               fl_pc = exp_pc;
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b0; sel = 1'b0; id_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; rdr = 1'b0; rdr_pc = 32'h0;
      gnt_delay = 0; slow_addr = 32'h1; r_lat = 1; resp_cnt = -1; gnt_wait = 0; resp_addr = 32'h0;

      // Sequential fetch with single-cycle memory
      do_reset(1'b0);
      id_ready = 1'b1;
      rst = 1'b1;
      wait_valid();
      chk("t1_instr", id_instr, 32'h0050_0093);
      chk("t1_op", 32'(id_op), 32'(7'b0010011));
      chk("t1_pc4", id_pc_plus4, 32'h4);
      repeat (8) tick();
      chk("t1_g0", at(grant_log, 0), 32'h0);
      chk("t1_g1", at(grant_log, 1), 32'h4);
      chk("t1_g2", at(grant_log, 2), 32'h8);
      chk("t1_p0", at(pop_log, 0), 32'h0);
      chk("t1_p1", at(pop_log, 1), 32'h4);
      chk("t1_p2", at(pop_log, 2), 32'h8);

      // Decode stalled: queue fills to two and fetching stops
      do_reset(1'b0);
      id_ready = 1'b0;
      rst = 1'b1;
      repeat (12) tick();
      chk("t2_ngrants", grant_log.size(), 2);
      chk("t2_req", 32'(imem_req), 32'd0);
      chk("t2_valid", 32'(id_valid), 32'd1);
      chk("t2_head", id_pc, 32'h0);
      id_ready = 1'b1;
      repeat (8) tick();
      chk("t2_p0", at(pop_log, 0), 32'h0);
      chk("t2_p1", at(pop_log, 1), 32'h4);
      chk("t2_g2", at(grant_log, 2), 32'h8);

      // Grant for 0x4 held off three cycles
      do_reset(1'b0);
      id_ready = 1'b1;
      slow_addr = 32'h4;
      gnt_delay = 3;
      rst = 1'b1;
      repeat (14) tick();
      n = 0;
      foreach (req_log[i]) if (req_log[i] == 32'h4) n++;
      chk("t3_req_cycles", n, 4);
      chk("t3_p1", at(pop_log, 1), 32'h4);
      chk("t3_p2", at(pop_log, 2), 32'h8);

      // Redirect while waiting for a slow response
      do_reset(1'b0);
      r_lat = 3;
      id_ready = 1'b1;
      rst = 1'b1;
      wait_grants(1);
      rdr = 1'b1;
      rdr_pc = 32'h100;
      tick();
      chk("t4_flushed", 32'(id_valid), 32'd0);
      repeat (12) tick();
      chk("t4_g1", at(grant_log, 1), 32'h100);
      chk("t4_p0", at(pop_log, 0), 32'h100);

      // Redirect coinciding with rvalid, unaligned target
      do_reset(1'b0);
      id_ready = 1'b0;
      rst = 1'b1;
      wait_grants(2);
      rdr = 1'b1;
      rdr_pc = 32'h203;
      tick();
      chk("t5_flushed", 32'(id_valid), 32'd0);
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_addr", imem_addr, 32'h200);
      id_ready = 1'b1;
      repeat (6) tick();
      chk("t5_g2", at(grant_log, 2), 32'h200);
      chk("t5_p0", at(pop_log, 0), 32'h200);

      // Reset PC at the top of the address space wraps to 0
      do_reset(1'b1);
      id_ready = 1'b1;
      rst = 1'b1;
      wait_valid();
      chk("t6_pc", id_pc, 32'hFFFF_FFFC);
      chk("t6_pc4", id_pc_plus4, 32'h0);
      repeat (4) tick();
      chk("t6_g1", at(grant_log, 1), 32'h0);
      chk("t6_p1", at(pop_log, 1), 32'h0);

      // Reset during WAIT; the stale response arrives after release and must be ignored
      do_reset(1'b1);
      r_lat = 4;
      id_ready = 1'b1;
      rst = 1'b1;
      wait_grants(1);
      slow_addr = 32'hFFFF_FFFC;
      gnt_delay = 4;
      rst = 1'b0;
      grant_log.delete();
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("t6_stale", 32'(id_valid), 32'd0);
      repeat (12) tick();
      chk("t6_rg0", at(grant_log, 0), 32'hFFFF_FFFC);
      chk("t6_npop", pop_log.size(), 1);
      chk("t6_rp0", at(pop_log, 0), 32'hFFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
